// File: rtl/packet_sf_fifo_pkg.sv
// Shared types and entry layout for packet_sf_fifo.
// Data-RAM entry holds the start, last and data fields of one beat.
package packet_sf_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int LAST_BIT  = 0;
    localparam int START_BIT = 1;
    localparam int DATA_LSB  = 2;

endpackage

// File: rtl/packet_sf_fifo_if.sv
// Head/data/start/last packet stream bundle for packet_sf_fifo.
// slave = the FIFO, master = producer/consumer environment.
interface packet_sf_fifo_if #(
    parameter int HW = 512,
    parameter int PW = 512
);
    logic          i_packet_in_valid;
    logic [HW-1:0] iv_packet_in_head;
    logic [PW-1:0] iv_packet_in_data;
    logic          i_packet_in_start;
    logic          i_packet_in_last;
    logic          o_packet_in_ready;
    logic          o_packet_out_valid;
    logic [HW-1:0] ov_packet_out_head;
    logic [PW-1:0] ov_packet_out_data;
    logic          o_packet_out_start;
    logic          o_packet_out_last;
    logic          i_packet_out_ready;

    modport slave (
        input  i_packet_in_valid,
        input  iv_packet_in_head,
        input  iv_packet_in_data,
        input  i_packet_in_start,
        input  i_packet_in_last,
        output o_packet_in_ready,
        output o_packet_out_valid,
        output ov_packet_out_head,
        output ov_packet_out_data,
        output o_packet_out_start,
        output o_packet_out_last,
        input  i_packet_out_ready
    );

    modport master (
        output i_packet_in_valid,
        output iv_packet_in_head,
        output iv_packet_in_data,
        output i_packet_in_start,
        output i_packet_in_last,
        input  o_packet_in_ready,
        input  o_packet_out_valid,
        input  ov_packet_out_head,
        input  ov_packet_out_data,
        input  o_packet_out_start,
        input  o_packet_out_last,
        output i_packet_out_ready
    );

endinterface

// File: rtl/packet_sf_fifo_ram.sv
// Simple dual-port synchronous RAM, one write and one read port.
// Read data is registered and holds while re is low.
module sf_dual_port_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/packet_sf_fifo.sv
// Store-and-forward packet FIFO; releases a packet once its last beat is stored.
// PKT_SF_FIFO_STATS_EN adds rx/tx packet counters.
module packet_sf_fifo
    import packet_sf_fifo_pkg::*;
#(
    parameter int HEADER_BUS_WIDTH  = 512,
    parameter int PAYLOAD_BUS_WIDTH = 512,
    parameter int DEPTH             = 64,
    parameter int ADDR_W            = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    packet_sf_fifo_if.slave bus,
`ifdef PKT_SF_FIFO_STATS_EN
    output logic [31:0]     ov_rx_pkt_cnt,
    output logic [31:0]     ov_tx_pkt_cnt,
`endif
    output logic            o_proto_err
);

    localparam int HW = HEADER_BUS_WIDTH;
    localparam int PW = PAYLOAD_BUS_WIDTH;
    localparam int EW = PW + DATA_LSB;
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t state, state_nx;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]     beat_cnt, beat_cnt_nx;
    logic [CW-1:0]     pkt_cnt, pkt_cnt_nx;
    logic              in_rdy, in_pkt, err;
    logic              acc, done, send;
    logic              pop, pop_last, re;
    logic              rd_start, rd_last;
    logic [EW-1:0]     wr_ent, rd_ent;
    logic [HW-1:0]     rd_head, head_q, head_cur;

    assign acc      = bus.i_packet_in_valid & in_rdy;
    assign done     = acc & bus.i_packet_in_last;
    assign send     = (state == ST_SEND);
    assign rd_start = rd_ent[START_BIT];
    assign rd_last  = rd_ent[LAST_BIT];
    assign pop      = send & bus.i_packet_out_ready;
    assign pop_last = pop & rd_last;
    // Prefetch the next beat on every non-final handshake so SEND has no bubbles.
    assign re       = (state == ST_LOAD) | (pop & ~rd_last);

    assign wr_ent = {bus.iv_packet_in_data,
                     bus.i_packet_in_start,
                     bus.i_packet_in_last};

    sf_dual_port_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_data_ram (
        .clk  (clk),
        .we   (acc),
        .waddr(wr_ptr),
        .wdata(wr_ent),
        .re   (re),
        .raddr(rd_ptr),
        .rdata(rd_ent)
    );

    // Header lives at the address of its start beat.
    sf_dual_port_ram #(
        .WIDTH (HW),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_head_ram (
        .clk  (clk),
        .we   (acc & bus.i_packet_in_start),
        .waddr(wr_ptr),
        .wdata(bus.iv_packet_in_head),
        .re   (re),
        .raddr(rd_ptr),
        .rdata(rd_head)
    );

    assign head_cur = rd_start ? rd_head : head_q;

    always_comb begin
        beat_cnt_nx = beat_cnt;
        if (acc && !pop) beat_cnt_nx = beat_cnt + ONE;
        if (!acc && pop) beat_cnt_nx = beat_cnt - ONE;
    end

    always_comb begin
        pkt_cnt_nx = pkt_cnt;
        if (done && !pop_last) pkt_cnt_nx = pkt_cnt + ONE;
        if (!done && pop_last) pkt_cnt_nx = pkt_cnt - ONE;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (pkt_cnt != '0) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_SEND;
            ST_SEND: begin
                if (pop_last)
                    state_nx = (pkt_cnt_nx != '0) ? ST_LOAD : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            in_rdy   <= 1'b0;
            in_pkt   <= 1'b0;
            err      <= 1'b0;
            head_q   <= '0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_cnt_nx;
            pkt_cnt  <= pkt_cnt_nx;
            in_rdy   <= (beat_cnt_nx != FULL);
            if (acc) wr_ptr <= wr_ptr + 1'b1;
            if (re) rd_ptr <= rd_ptr + 1'b1;
            if (acc) in_pkt <= ~bus.i_packet_in_last;
            // start must be set exactly when no packet is open
            if (acc && (in_pkt == bus.i_packet_in_start)) err <= 1'b1;
            if (send) head_q <= head_cur;
        end
    end

    assign bus.o_packet_in_ready  = in_rdy;
    assign bus.o_packet_out_valid = send;
    assign bus.ov_packet_out_head = send ? head_cur : '0;
    assign bus.ov_packet_out_data = send ? rd_ent[DATA_LSB +: PW] : '0;
    assign bus.o_packet_out_start = send & rd_start;
    assign bus.o_packet_out_last  = send & rd_last;
    assign o_proto_err            = err;

`ifdef PKT_SF_FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_rx_pkt_cnt <= '0;
            ov_tx_pkt_cnt <= '0;
        end else begin
            if (done) ov_rx_pkt_cnt <= ov_rx_pkt_cnt + 32'd1;
            if (pop_last) ov_tx_pkt_cnt <= ov_tx_pkt_cnt + 32'd1;
        end
    end
`endif

endmodule
